// File: rtl/fetchflare_fifo_reader_if.sv
// Handshake bundle for the FIFO read adapter: FIFO read port on one side,
// valid/ready output stream with occupancy on the other.
interface fetchflare_fifo_reader_if #(
    parameter int Dw = 160
);
    logic          fifo_empty;
    logic [Dw-1:0] fifo_dout;
    logic          fifo_rd_en;
    logic [Dw-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [1:0]    level;

    modport slave (
        input  fifo_empty, fifo_dout, out_ready,
        output fifo_rd_en, out_data, out_valid, level
    );

    modport master (
        output fifo_empty, fifo_dout, out_ready,
        input  fifo_rd_en, out_data, out_valid, level
    );
endinterface

// File: rtl/fetchflare_fifo_reader.sv
// Drains a registered-output (non-FWFT) FIFO into an in-order valid/ready stream
// through a 3-entry buffer; out_ready never reaches fifo_rd_en combinationally.
module fetchflare_fifo_reader #(
    parameter int Dw = 160
) (
    input  logic                      clk,
    input  logic                      reset,
    fetchflare_fifo_reader_if.slave   bus
);

    logic [Dw-1:0] entry_q [3];
    logic [Dw-1:0] entry_d [3];
    logic [1:0]    wptr_q, wptr_d;
    logic [1:0]    rptr_q, rptr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          inflight_q;

    logic [2:0]    commit_s;
    logic          rd_en_s;
    logic          valid_s;
    logic          pop_s;
    logic [Dw-1:0] head_s;

    function automatic logic [1:0] ptr_inc(input logic [1:0] ptr);
        case (ptr)
            2'd0:    ptr_inc = 2'd1;
            2'd1:    ptr_inc = 2'd2;
            default: ptr_inc = 2'd0;
        endcase
    endfunction

    // Read issue, pop qualification and head-word selection
    always_comb begin
        // buffered words plus the word still in flight must leave room for one more
        commit_s = {1'b0, cnt_q} + {2'b00, inflight_q};
        rd_en_s  = ~reset & ~bus.fifo_empty & (commit_s < 3'd3);
        valid_s  = (cnt_q != 2'd0);
        pop_s    = valid_s & bus.out_ready;
        case (rptr_q)
            2'd0:    head_s = entry_q[0];
            2'd1:    head_s = entry_q[1];
            2'd2:    head_s = entry_q[2];
            default: head_s = '0;
        endcase
    end

    // Next-state for storage, pointers and occupancy
    always_comb begin
        entry_d = entry_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        if (inflight_q) begin
            for (int i = 0; i < 3; i++) begin
                if (wptr_q == 2'(i)) begin
                    entry_d[i] = bus.fifo_dout;
                end else begin
                    entry_d[i] = entry_q[i];
                end
            end
            wptr_d = ptr_inc(wptr_q);
        end else begin
            wptr_d = wptr_q;
        end
        if (pop_s) begin
            rptr_d = ptr_inc(rptr_q);
        end else begin
            rptr_d = rptr_q;
        end
        case ({inflight_q, pop_s})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                entry_q[i] <= '0;
            end
            wptr_q     <= 2'd0;
            rptr_q     <= 2'd0;
            cnt_q      <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            entry_q    <= entry_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            inflight_q <= rd_en_s;
        end
    end

    assign bus.fifo_rd_en = rd_en_s;
    assign bus.out_valid  = valid_s;
    assign bus.out_data   = head_s;
    assign bus.level      = cnt_q;

endmodule

// File: tb/tb_fetchflare_fifo_reader.sv
// Bench for fetchflare_fifo_reader: a registered-read FIFO model feeds the DUT and
// an ordered queue of pushed words is the reference for what must come out.
module tb_fetchflare_fifo_reader;

    localparam int DW   = 160;
    localparam int MEMD = 2048;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetchflare_fifo_reader_if #(.Dw(DW)) bus ();

    fetchflare_fifo_reader #(.Dw(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // FIFO model: storage array, write count from the stimulus, read index on clock
    logic [DW-1:0] mem [MEMD];
    int unsigned   wr_cnt = 0;
    int unsigned   rd_idx = 0;
    logic [DW-1:0] dout_r = '0;
    logic [DW-1:0] exp_q [$];

    int n_checks = 0;
    int n_fail   = 0;

    assign bus.fifo_empty = (rd_idx == wr_cnt);
    assign bus.fifo_dout  = dout_r;

    // Registered read; the FIFO shares reset and loses its contents on it
    always @(posedge clk) begin
        if (reset) begin
            rd_idx <= wr_cnt;
            dout_r <= '0;
        end else if (bus.fifo_rd_en && (rd_idx != wr_cnt)) begin
            dout_r <= mem[rd_idx % MEMD];
            rd_idx <= rd_idx + 1;
        end
    end

    function automatic logic [DW-1:0] mkword(input logic [31:0] tag);
        mkword = {tag, 32'($urandom), 32'($urandom), 32'($urandom), 32'($urandom)};
    endfunction

    task automatic push(input logic [DW-1:0] w);
        mem[wr_cnt % MEMD] = w;
        wr_cnt = wr_cnt + 1;
        exp_q.push_back(w);
    endtask

    task automatic test_reset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(mkword(32'h0000_0100 + 32'(i)));
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (bus.fifo_rd_en !== 1'b0) begin
                n_fail++; $display("FAIL reset_rd_en cyc=%0d got %b want 0", k, bus.fifo_rd_en);
            end
        end
        reset = 1'b0;
        exp_q.delete();
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid got %b want 0", bus.out_valid);
        end
        n_checks++;
        if (bus.level !== 2'd0) begin
            n_fail++; $display("FAIL reset_level got %0d want 0", bus.level);
        end
        n_checks++;
        if (bus.out_data !== {DW{1'b0}}) begin
            n_fail++; $display("FAIL reset_data got %h want 0", bus.out_data);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        bus.out_ready = 1'b1;
        push(DW'(8'hA5));
        #1;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            n_checks++;
            if (bus.fifo_rd_en !== (k == 0)) begin
                n_fail++; $display("FAIL single_rd_en cyc=%0d got %b want %b", k, bus.fifo_rd_en, (k == 0));
            end
            n_checks++;
            if (bus.out_valid !== (k == 2)) begin
                n_fail++; $display("FAIL single_valid cyc=%0d got %b want %b", k, bus.out_valid, (k == 2));
            end
            n_checks++;
            if (bus.level !== ((k == 2) ? 2'd1 : 2'd0)) begin
                n_fail++; $display("FAIL single_level cyc=%0d got %0d want %0d", k, bus.level, (k == 2));
            end
            if (k == 2) begin
                n_checks++;
                if (bus.out_data !== DW'(8'hA5)) begin
                    n_fail++; $display("FAIL single_data got %h want a5", bus.out_data);
                end
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic test_streaming();
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) push(DW'(i));
        #1;
        for (int k = 0; k < 22; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            n_checks++;
            if (bus.fifo_rd_en !== (k < 16)) begin
                n_fail++; $display("FAIL stream_rd_en cyc=%0d got %b want %b", k, bus.fifo_rd_en, (k < 16));
            end
            n_checks++;
            if (bus.out_valid !== (k >= 2 && k < 18)) begin
                n_fail++; $display("FAIL stream_valid cyc=%0d got %b want %b", k, bus.out_valid, (k >= 2 && k < 18));
            end
            if (k >= 2 && k < 18) begin
                n_checks++;
                if (bus.out_data !== DW'(k - 1)) begin
                    n_fail++; $display("FAIL stream_data cyc=%0d got %h want %0d", k, bus.out_data, k - 1);
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic test_backpressure();
        int rd_cnt;
        rd_cnt = 0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(mkword(32'h0000_8000 + 32'(i)));
        #1;
        for (int k = 0; k < 10; k++) begin
            if (k > 0) begin @(negedge clk); #1; end
            if (bus.fifo_rd_en === 1'b1) rd_cnt++;
            if (k >= 4) begin
                n_checks++;
                if (bus.level !== 2'd3) begin
                    n_fail++; $display("FAIL bp_level cyc=%0d got %0d want 3", k, bus.level);
                end
                n_checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== exp_q[0]) begin
                    n_fail++; $display("FAIL bp_hold cyc=%0d got %b/%h want 1/%h", k, bus.out_valid, bus.out_data, exp_q[0]);
                end
            end
        end
        n_checks++;
        if (rd_cnt != 3) begin
            n_fail++; $display("FAIL bp_reads got %0d want 3", rd_cnt);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            bus.out_ready = 1'b1;
            #1;
            n_checks++;
            if (bus.out_valid !== 1'b1 || exp_q.size() == 0) begin
                n_fail++; $display("FAIL bp_drain_valid cyc=%0d got %b want 1", k, bus.out_valid);
            end else begin
                n_checks++;
                if (bus.out_data !== exp_q[0]) begin
                    n_fail++; $display("FAIL bp_drain_data cyc=%0d got %h want %h", k, bus.out_data, exp_q[0]);
                end
                void'(exp_q.pop_front());
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            n_checks++;
            if (bus.out_valid !== 1'b0) begin
                n_fail++; $display("FAIL bp_empty cyc=%0d got %b want 0", k, bus.out_valid);
            end
        end
    endtask

    task automatic test_random();
        int pushed, delivered, cyc;
        pushed = 0; delivered = 0; cyc = 0;
        while (delivered < 1000 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (pushed < 1000 && $urandom_range(0, 2) != 0) begin
                push(mkword(32'h1000_0000 + 32'(pushed)));
                pushed++;
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            #1;
            n_checks++;
            if (bus.fifo_rd_en === 1'b1 && bus.fifo_empty === 1'b1) begin
                n_fail++; $display("FAIL rand_rd_empty cyc=%0d got rd_en=1 want 0 while empty", cyc);
            end
            n_checks++;
            if (bus.out_valid !== (bus.level != 2'd0)) begin
                n_fail++; $display("FAIL rand_valid_level cyc=%0d got valid=%b level=%0d", cyc, bus.out_valid, bus.level);
            end
            if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL rand_extra cyc=%0d got %h want no word", cyc, bus.out_data);
                end else begin
                    if (bus.out_data !== exp_q[0]) begin
                        n_fail++; $display("FAIL rand_order cyc=%0d got %h want %h", cyc, bus.out_data, exp_q[0]);
                    end
                    void'(exp_q.pop_front());
                end
                delivered++;
            end
        end
        n_checks++;
        if (delivered != 1000 || exp_q.size() != 0) begin
            n_fail++; $display("FAIL rand_done got %0d delivered want 1000 (pending %0d)", delivered, exp_q.size());
        end
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(mkword(32'hDEAD_0000 + 32'(i)));
        #1;
        for (int k = 1; k <= 3; k++) begin @(negedge clk); #1; end
        n_checks++;
        if (bus.level !== 2'd2) begin
            n_fail++; $display("FAIL mid_setup_level got %0d want 2", bus.level);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.fifo_rd_en !== 1'b0) begin
            n_fail++; $display("FAIL mid_rd_en got %b want 0", bus.fifo_rd_en);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        #1;
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.level !== 2'd0) begin
            n_fail++; $display("FAIL mid_cleared got valid=%b level=%0d want 0/0", bus.out_valid, bus.level);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) push(mkword(32'h5000_0000 + 32'(i)));
        for (int k = 0; k < 10; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            if (bus.out_valid === 1'b1) begin
                n_checks++;
                if (exp_q.size() == 0 || bus.out_data !== exp_q[0]) begin
                    n_fail++; $display("FAIL mid_after cyc=%0d got %h want %h", k, bus.out_data,
                                       (exp_q.size() != 0) ? exp_q[0] : {DW{1'b0}});
                end
                if (exp_q.size() != 0) void'(exp_q.pop_front());
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL mid_done got %0d pending want 0", exp_q.size());
        end
    endtask

    initial begin
        bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_streaming();
        test_backpressure();
        test_random();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetchflare_fifo_reader.md
# fetchflare_fifo_reader

Read-side adapter for the prefetcher's BRAM-based FIFOs. It drains a FIFO that has registered read data (data appears one cycle after the read strobe, no first-word-fall-through). It presents the words downstream as an in-order valid/ready stream. A 3-entry output buffer gives full throughput with no combinational path from `out_ready` to `fifo_rd_en`. The block sits between the prefetch data/request FIFOs and their consumers, such as the response mux and the memory request port.

## Interface
- `Dw`, default 160, width of FIFO words and of `out_data`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_dout`  in  Dw  FIFO registered read data; valid in the cycle after `fifo_rd_en` is asserted.
- `fifo_rd_en`  out  1  FIFO read strobe.
- `out_data`  out  Dw  head word of the output buffer.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_ready`  in  1  downstream accepts `out_data` this cycle.
- `level`  out  2  number of words held in the output buffer (0..3); excludes the in-flight read.

## Operation
- State:
  - Storage: 3 entries of Dw bits.
  - Pointers: `wptr` and `rptr`, each 2 bits, range 0..2. Each wraps 2→0.
  - Counter: `cnt` (0..3).
  - Flag: `inflight`, a 1-bit register, set when a read was issued in the previous cycle.
- Read issue: `fifo_rd_en = ~reset & ~fifo_empty & (cnt + inflight < 3)`.
  - Depends only on registers and `fifo_empty`.
  - The block never reads an empty FIFO.
  - The block never over-commits the buffer.
- Next-cycle flag: `inflight <= fifo_rd_en`.
- Capture: when `inflight` = 1, `fifo_dout` is written to `entry[wptr]` at the clock edge, and `wptr` advances.
- Pop: `pop = out_valid & out_ready`. On pop, `rptr` advances.
- Output signals: `out_valid = (cnt != 0)`. `out_data = entry[rptr]`. `level = cnt`.
- Count update:
  - Capture only: `cnt` +1.
  - Pop only: `cnt` −1.
  - Capture and pop in the same cycle: `cnt` unchanged.
  - Both pointers still advance.
- Ordering: words leave in exactly the order they were read from the FIFO. There is no loss, duplication or reordering.
- Stability: while `out_valid` = 1 and `out_ready` = 0, `out_data` and `out_valid` hold unchanged.
- `out_ready` asserted while `out_valid` = 0 has no effect.
- Arithmetic: `cnt + inflight` is evaluated at 3-bit width. The comparison against 3 is unsigned.

## Timing
- Reset values (cycle after `reset` is sampled high):
  - `cnt` = 0, `inflight` = 0, `wptr` = `rptr` = 0, all entries = 0.
  - Outputs: `out_valid` = 0, `out_data` = 0, `level` = 0.
  - `fifo_rd_en` = 0 throughout the reset cycle(s).
- Latency: `fifo_rd_en` high in cycle t → word captured at the end of t+1 → `out_valid` high in t+2. Minimum FIFO-to-output latency is 2 cycles.
- Throughput: with `out_ready` held high and the FIFO non-empty, `fifo_rd_en` is asserted every cycle, giving one word per cycle. Steady state is `cnt` = 1, `inflight` = 1.
- Backpressure: with `out_ready` = 0, at most 3 reads are issued. After that `fifo_rd_en` stays low. `level` = 3 is the boundary at which reads stop.
- When `fifo_empty` rises, reads stop the same cycle. A read already in flight is still captured.
- Reset mid-operation:
  - Buffered words and any in-flight word are discarded.
  - The attached FIFO shares `reset` and is reset in the same cycle.
  - No `fifo_rd_en` is issued in the reset cycle.

## Test plan
- Reset: hold `reset` for 2 cycles with the FIFO non-empty. Required: `fifo_rd_en` = 0 during reset; `out_valid` = 0, `level` = 0 and `out_data` = 0 after reset.
- Single word: FIFO holds 0xA5, `out_ready` = 1.
  - `fifo_rd_en` pulses in cycle 0 only.
  - `out_valid` = 1 with `out_data` = 0xA5 in cycle 2 only.
  - `level` = 1 in cycle 2, then 0.
- Streaming: FIFO preloaded with words 1..16, `out_ready` = 1.
  - `fifo_rd_en` is high for 16 consecutive cycles.
  - `out_valid` is high for 16 consecutive cycles starting 2 cycles later.
  - Data arrives as 1..16 in order.
- Backpressure: FIFO holds 8 words, `out_ready` = 0.
  - Exactly 3 `fifo_rd_en` pulses occur, then `level` = 3 holds and `out_data` = word 1 stays stable.
  - Raise `out_ready`: words 1..8 emerge in order with no gap after the first.
- Random: 1000 words are written to the FIFO with random gaps while `out_ready` toggles randomly.
  - A scoreboard checks in-order, lossless delivery.
  - `fifo_rd_en` is never asserted with `fifo_empty` = 1.
  - `level` never exceeds 3.
- Mid-operation reset: assert `reset` in the cycle where `inflight` = 1 and `level` = 2. Required: `out_valid` = 0 and `level` = 0 next cycle, and the discarded word never appears on the output afterwards.
